// File: rtl/dds_param_loader.sv
// Byte-stream command parser for the two-channel DDS core.
// Writes land in shadow words; a COMMIT copies every shadow word to the active outputs at once.
module dds_param_loader #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned TW      = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] amps,
  output logic [31:0] offsets,
  output logic [31:0] phasewords,
  output logic        commit_pulse,
  output logic        err_pulse,
  output logic        busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GET_HI = 2'd1;
  localparam logic [1:0] GET_LO = 2'd2;
  localparam logic [1:0] COMMIT = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tcnt_q;
  logic [7:0]    hi_q;
  logic          chan_q;
  logic [1:0]    field_q;
  logic [31:0]   sh_amps_q, sh_offs_q, sh_phw_q;

  logic accept, in_frame, cmd_write, cmd_commit, cmd_bad, timeout_hit;
  logic unused_bits;

  assign in_ready    = (state_q != COMMIT);
  assign busy        = (state_q != IDLE);
  assign accept      = in_valid && in_ready;
  assign in_frame    = (state_q == GET_HI) || (state_q == GET_LO);
  assign cmd_write   = (in_data[7:6] == 2'b00) && (in_data[1:0] != 2'b11);
  assign cmd_commit  = (in_data[7:6] == 2'b01);
  assign cmd_bad     = !cmd_write && !cmd_commit;
  assign unused_bits = ^in_data[5:3];
  // An accepted byte wins over the timeout on the same edge.
  assign timeout_hit = in_frame && !accept && (tcnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept && cmd_write) begin
          state_d = GET_HI;
        end else if (accept && cmd_commit) begin
          state_d = COMMIT;
        end
      end
      GET_HI: begin
        if (accept) begin
          state_d = GET_LO;
        end else if (timeout_hit) begin
          state_d = IDLE;
        end
      end
      GET_LO: begin
        if (accept || timeout_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      tcnt_q       <= '0;
      hi_q         <= '0;
      chan_q       <= 1'b0;
      field_q      <= 2'b00;
      sh_amps_q    <= '0;
      sh_offs_q    <= '0;
      sh_phw_q     <= '0;
      amps         <= '0;
      offsets      <= '0;
      phasewords   <= '0;
      commit_pulse <= 1'b0;
      err_pulse    <= 1'b0;
    end else begin
      state_q      <= state_d;
      commit_pulse <= (state_q == COMMIT);
      err_pulse    <= ((state_q == IDLE) && accept && cmd_bad) || timeout_hit;

      if (!in_frame || accept || timeout_hit) begin
        tcnt_q <= '0;
      end else begin
        tcnt_q <= tcnt_q + 1'b1;
      end

      if ((state_q == IDLE) && accept && cmd_write) begin
        chan_q  <= in_data[2];
        field_q <= in_data[1:0];
      end

      if ((state_q == GET_HI) && accept) begin
        hi_q <= in_data;
      end

      if ((state_q == GET_LO) && accept) begin
        unique case (field_q)
          2'b00: begin
            if (chan_q) sh_amps_q[31:16] <= {hi_q, in_data};
            else        sh_amps_q[15:0]  <= {hi_q, in_data};
          end
          2'b01: begin
            if (chan_q) sh_offs_q[31:16] <= {hi_q, in_data};
            else        sh_offs_q[15:0]  <= {hi_q, in_data};
          end
          default: begin
            if (chan_q) sh_phw_q[31:16] <= {hi_q, in_data};
            else        sh_phw_q[15:0]  <= {hi_q, in_data};
          end
        endcase
      end

      if (state_q == COMMIT) begin
        amps       <= sh_amps_q;
        offsets    <= sh_offs_q;
        phasewords <= sh_phw_q;
      end
    end
  end

endmodule

// File: doc/dds_param_loader.md
Name: dds_param_loader

Overview:
- Byte-stream command parser that writes the packed per-channel amplitude, phase-offset and phase-increment words consumed by the two-channel DDS summing block.
- Writes land in shadow registers.
- A commit command copies all shadow words to the active outputs in one cycle, so both channels retune glitch-free and phase-coherent.
- Sits between the host byte interface (UART/SPI front end) and the DDS core.

Parameters:
- TIMEOUT, 1024, idle clock cycles allowed between bytes of one frame before the frame is aborted (minimum 2).
- TW, $clog2(TIMEOUT+1), width of the inter-byte timeout counter (derived; do not override).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- in_data  in  8  command/data byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  parser can accept a byte; a byte transfers on an edge where in_valid && in_ready.
- amps  out  32  active amplitudes; [31:16] channel 1, [15:0] channel 0 (signed).
- offsets  out  32  active phase offsets; [31:16] ch1, [15:0] ch0.
- phasewords  out  32  active phase increments; [31:16] ch1, [15:0] ch0.
- commit_pulse  out  1  high for exactly one cycle when the active outputs were just loaded.
- err_pulse  out  1  high one cycle on a bad command or a frame timeout.
- busy  out  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (reset=0, async): amps, offsets, phasewords, all six shadow words, commit_pulse, err_pulse and the timeout counter = 0; state = IDLE; in_ready = 1.
- Command byte: [7:6] opcode (00 WRITE, 01 COMMIT, 1x illegal); [5:3] ignored; [2] channel; [1:0] field (00 amp, 01 offset, 10 phaseword, 11 illegal).
- WRITE frame: 3 bytes (command, value[15:8], value[7:0]). COMMIT frame: 1 byte.
- States and transitions:
  - IDLE --legal WRITE--> GET_HI
  - IDLE --COMMIT--> COMMIT
  - IDLE --illegal opcode or field--> IDLE, err_pulse=1 next cycle, byte discarded
  - GET_HI --byte--> GET_LO (hi byte latched)
  - GET_LO --byte--> IDLE; selected shadow word = {hi,lo} on that same edge
  - COMMIT --unconditional--> IDLE; amps/offsets/phasewords <= shadow; commit_pulse=1 for the following cycle
- in_ready: 1 in IDLE, GET_HI, GET_LO; 0 in COMMIT. Commit therefore costs one stall cycle.
- Latency:
  - COMMIT byte accepted at edge k -> outputs change at edge k+1; commit_pulse high during cycle k+1..k+2.
  - Shadow write visible at outputs only after a subsequent commit.
- Shadow words persist across commits; unchanged fields re-commit their old values.
- Timeout:
  - In GET_HI/GET_LO the counter increments each cycle with no accepted byte and clears on each accepted byte.
  - When it reaches TIMEOUT: state -> IDLE, err_pulse one cycle, partial value discarded, shadow untouched.
  - A byte accepted on the same edge the count would hit TIMEOUT is accepted normally; no timeout occurs.
- Illegal command byte mid-frame is impossible: bytes in GET_HI/GET_LO are data, never decoded.
- Back-to-back frames: a new command may be accepted on the edge right after the GET_LO edge; no gap is required.
- commit_pulse and err_pulse are registered and never high together.
- reset asserted mid-frame or mid-commit aborts everything: active and shadow words return to 0 and no pulse is emitted.
- Output widths are exact; no sign extension or arithmetic is performed on values.

Test Plan:
- Reset then idle 10 cycles -> amps=offsets=phasewords=0, in_ready=1, busy=0, no pulses.
- Write bytes 0x00,0x12,0x34 (ch0 amp) and 0x06,0xAB,0xCD (ch1 phaseword), then commit 0x40 -> before commit, outputs remain 0. One cycle after the commit byte: amps=0x00001234, phasewords=0xABCD0000, commit_pulse single cycle, in_ready=0 for exactly one cycle.
- Send 0x03 (field 11), then 0x80 (illegal opcode) -> err_pulse twice, state stays IDLE, shadow unchanged (a following commit leaves outputs identical).
- Send 0x01,0x55, then hold in_valid=0 for TIMEOUT cycles -> err_pulse, busy drops. A subsequent 0x01,0x77,0x88 + commit gives offsets[15:0]=0x7788.
- Mid-frame, drive the byte stream with continuous in_valid and random in_ready-compatible gaps shorter than TIMEOUT -> all frames decode correctly, no err_pulse.
- Load non-zero values and commit, send 0x00,0xFF, then assert reset=0 asynchronously between edges -> all outputs 0 immediately. After release, a bare commit keeps outputs 0.
